load_store_unit: RTL and testbench

//  Sits between the execute stage and data_memory. Takes one load/store request per handshake.

---
 rtl/load_store_unit_pkg.sv | 21 ++
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit_align.sv | 39 +++
 rtl/load_store_unit.sv | 103 ++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 codes, FSM state type and alignment helper for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} lsu_state_t;

  // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake bundle between execute stage and LSU
interface load_store_unit_if #(parameter int A = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [A-1:0]  req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - load byte/half extract with extension, store byte/half merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_word = old_word;
    case (funct3)
      F3_B:    store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit driving a word-addressed memory without byte enables
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int A     = 32,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          rst,
  load_store_unit_if.slave bus,
  output logic          mem_we,
  output logic [A-1:0]  mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  lsu_state_t  state;
  logic [1:0]  offset_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        illegal;
  logic        out_of_range;
  logic        err;
  logic        is_sw;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign illegal      = we_q ? !(funct3_q inside {F3_B, F3_H, F3_W})
                             : (funct3_q inside {3'b011, 3'b110, 3'b111});
  assign out_of_range = mem_addr >= A'(DEPTH);
  assign err          = illegal || out_of_range || is_misaligned(funct3_q, offset_q);
  assign is_sw        = we_q && (funct3_q == F3_W);

  lsu_align u_align (
    .word       (mem_rdata),
    .old_word   (old_q),
    .wdata      (wdata_q),
    .funct3     (funct3_q),
    .offset     (offset_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Write strobe is decoded from state so an asynchronous reset kills it immediately.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    if (state == ACCESS && !err && is_sw) begin
      mem_we    = 1'b1;
      mem_wdata = wdata_q;
    end else if (state == RMW_WR) begin
      mem_we    = 1'b1;
      mem_wdata = store_word;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      offset_q <= 2'b00;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      old_q    <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          offset_q <= bus.req_addr[1:0];
          mem_addr <= bus.req_addr >> 2;
          we_q     <= bus.req_we;
          funct3_q <= bus.req_funct3;
          wdata_q  <= bus.req_wdata;
          state    <= ACCESS;
        end
        ACCESS: begin
          err_q   <= err;
          rdata_q <= (err || we_q) ? 32'h0 : load_data;
          if (!err && we_q && !is_sw) begin
            old_q <= mem_rdata;
            state <= RMW_WR;
          end else begin
            state <= RESP;
          end
        end
        RMW_WR: state <= RESP;
        RESP:   if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a behavioural data memory
module tb_load_store_unit;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [0:DEPTH-1];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = 12'h0;
  logic [31:0] pre_data = 32'h0;
  int          pulses = 0;
  int          checks = 0;
  int          errors = 0;

  load_store_unit_if #(.A(32)) bus ();

  load_store_unit #(.A(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[11:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
      pulses <= pulses + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          npulse;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Latency counts the accept cycle as cycle 0's successor: first negedge after accept is 1.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic er, output int lat);
    int k;
    @(negedge clk);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          p0;

    vecs[0]  = '{"lb_14",   1'b0, 3'b000, 32'h14,   32'h0,        32'h0000_0001, 1'b0, 2, 0};
    vecs[1]  = '{"lb_15",   1'b0, 3'b000, 32'h15,   32'h0,        32'h0000_007F, 1'b0, 2, 0};
    vecs[2]  = '{"lb_16",   1'b0, 3'b000, 32'h16,   32'h0,        32'hFFFF_FFFF, 1'b0, 2, 0};
    vecs[3]  = '{"lb_17",   1'b0, 3'b000, 32'h17,   32'h0,        32'hFFFF_FF80, 1'b0, 2, 0};
    vecs[4]  = '{"lbu_17",  1'b0, 3'b100, 32'h17,   32'h0,        32'h0000_0080, 1'b0, 2, 0};
    vecs[5]  = '{"lhu_14",  1'b0, 3'b101, 32'h14,   32'h0,        32'h0000_7F01, 1'b0, 2, 0};
    vecs[6]  = '{"lh_16",   1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFF_80FF, 1'b0, 2, 0};
    vecs[7]  = '{"sb_09",   1'b1, 3'b000, 32'h09,   32'h3C,       32'h0,         1'b0, 3, 1};
    vecs[8]  = '{"lw_08a",  1'b0, 3'b010, 32'h08,   32'h0,        32'hA5A5_3CA5, 1'b0, 2, 0};
    vecs[9]  = '{"sh_0b",   1'b1, 3'b001, 32'h0B,   32'h1234,     32'h0,         1'b1, 2, 0};
    vecs[10] = '{"lw_02",   1'b0, 3'b010, 32'h02,   32'h0,        32'h0,         1'b1, 2, 0};
    vecs[11] = '{"lw_oor",  1'b0, 3'b010, 32'h4000, 32'h0,        32'h0,         1'b1, 2, 0};
    vecs[12] = '{"lw_last", 1'b0, 3'b010, 32'h3FFC, 32'h0,        32'h1234_5678, 1'b0, 2, 0};
    vecs[13] = '{"sw_10",   1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,         1'b0, 2, 1};
    vecs[14] = '{"lh_12",   1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFF_DEAD, 1'b0, 2, 0};
    vecs[15] = '{"lhu_12",  1'b0, 3'b101, 32'h12,   32'h0,        32'h0000_DEAD, 1'b0, 2, 0};
    vecs[16] = '{"sh_0a",   1'b1, 3'b001, 32'h0A,   32'h0000_BEEF, 32'h0,        1'b0, 3, 1};
    vecs[17] = '{"lw_08b",  1'b0, 3'b010, 32'h08,   32'h0,        32'hBEEF_3CA5, 1'b0, 2, 0};
    vecs[18] = '{"ld_f3_3", 1'b0, 3'b011, 32'h00,   32'h0,        32'h0,         1'b1, 2, 0};
    vecs[19] = '{"st_f3_4", 1'b1, 3'b100, 32'h20,   32'h55,       32'h0,         1'b1, 2, 0};
    vecs[20] = '{"sb_13",   1'b1, 3'b000, 32'h13,   32'h77,       32'h0,         1'b0, 3, 1};
    vecs[21] = '{"lw_10",   1'b0, 3'b010, 32'h10,   32'h0,        32'h77AD_BEEF, 1'b0, 2, 0};
    vecs[22] = '{"lb_10",   1'b0, 3'b000, 32'h10,   32'h0,        32'hFFFF_FFEF, 1'b0, 2, 0};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;

    preload(12'd5, 32'h80FF_7F01);
    preload(12'd2, 32'hA5A5_A5A5);
    preload(12'd7, 32'h1122_3344);
    preload(12'd4095, 32'h1234_5678);

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      p0 = pulses;
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
      chk({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].err));
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, "_pulses"}, 32'(pulses - p0), 32'(vecs[i].npulse));
    end
    chk("mem2_final", mem[2], 32'hBEEF_3CA5);

    // Response back-pressure: outputs must hold while rsp_ready is low.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h14; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_rdata", bus.rsp_rdata, 32'h80FF_7F01);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_req_ready", 32'(bus.req_ready), 32'd1);
    chk("release_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset during RMW_WR must kill the write strobe before the next edge.
    p0 = pulses;
    bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h1C;
    bus.req_wdata = 32'h55; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_mem_we_high", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_we_drop", 32'(mem_we), 32'd0);
    chk("rst_abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_abort_mem7", mem[7], 32'h1122_3344);
    chk("rst_abort_pulses", 32'(pulses - p0), 32'd0);

    do_req(1'b0, 3'b010, 32'h1C, 32'h0, rd, er, lat);
    chk("post_rst_lw_rdata", rd, 32'h1122_3344);
    chk("post_rst_lw_err", 32'(er), 32'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
